// File: rtl/one_unit_scale_if.sv
// one_unit_scale_if: element stream bundle for one_unit_scale.
//   in_valid/in_ready/in_data      : input element handshake (signed DW)
//   out_valid/out_ready/out_data   : output element handshake (signed DW)
//   out_idx                        : row-major element index of out_data
//   out_last                       : out_idx is the last element of the frame
//   ovf                            : out_data was clamped (saturating build only)
// Modports: master = producer/consumer side (testbench or upstream logic),
//           slave  = the scaler itself.
interface one_unit_scale_if #(
  parameter int unsigned DW = 26,
  parameter int unsigned IW = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, ovf
  );
endinterface

// File: rtl/one_unit_scale.sv
// one_unit_scale: streaming scaler for an N x N weight matrix, one element per cycle.
// Each element is multiplied by an unsigned coefficient (latched at element 0 of each
// frame) or bypassed, through a two-stage pipeline with valid/ready flow control.
// k_mul = 3, en_mul = 1 reproduces the legacy w <- 3w step.
//
// Ports:
//   clk_mul   : clock, rising edge
//   rstn_mul  : asynchronous active-low reset
//   clr_mul   : synchronous clear; flushes the pipeline and zeroes the index counter
//   en_mul    : 1 = scale, 0 = bypass; sampled with each element
//   k_mul     : unsigned coefficient, taken on acceptance of element 0
//   bus       : element stream (one_unit_scale_if, slave modport)
//
// Build option: define ONE_UNIT_SCALE_SAT_EN to saturate out-of-range products and flag
// them on ovf; otherwise products wrap to DW bits and ovf is tied 0.
module one_unit_scale #(
  parameter int unsigned DW = 26,
  parameter int unsigned N  = 4,
  parameter int unsigned KW = 4
) (
  input  logic                 clk_mul,
  input  logic                 rstn_mul,
  input  logic                 clr_mul,
  input  logic                 en_mul,
  input  logic [KW-1:0]        k_mul,
  one_unit_scale_if.slave      bus
);

  localparam int unsigned IW = $clog2(N * N);
  localparam logic [IW-1:0] LastIdx = IW'(N * N - 1);
`ifdef ONE_UNIT_SCALE_SAT_EN
  // Full product width so range can be judged in stage 2.
  localparam int unsigned PW = DW + KW + 1;
`else
  // Wrapping only needs the low DW bits of the product.
  localparam int unsigned PW = DW;
`endif

  // Flow control
  logic s1_valid_q, s2_valid_q;
  logic s1_load, s2_load, accept;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load && !clr_mul && rstn_mul;
  assign accept       = bus.in_valid && bus.in_ready;

  // Input index and coefficient hold
  logic [IW-1:0] idx_in_q, idx_in_next;
  logic [KW-1:0] k_hold_q, k_cur, k_sel;

  assign idx_in_next = (idx_in_q == LastIdx) ? '0 : idx_in_q + IW'(1);
  // Element 0 uses the live coefficient; the rest of the frame uses the held one.
  assign k_cur = (idx_in_q == '0) ? k_mul : k_hold_q;
  // Bypass is folded into the multiply as k = 1, which is exact and never overflows.
  assign k_sel = en_mul ? k_cur : KW'(1);

  logic signed [PW-1:0] data_ext, k_ext, prod;

  assign data_ext = PW'(bus.in_data);     // sign-extends
  assign k_ext    = PW'({1'b0, k_sel});   // zero-extends
  assign prod     = data_ext * k_ext;

  // Stage 1
  logic signed [PW-1:0] s1_prod_q;
  logic [IW-1:0]        s1_idx_q;
`ifdef ONE_UNIT_SCALE_SAT_EN
  logic                 s1_en_q;
`endif

  always_ff @(posedge clk_mul or negedge rstn_mul) begin
    if (!rstn_mul) begin
      idx_in_q   <= '0;
      k_hold_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_idx_q   <= '0;
`ifdef ONE_UNIT_SCALE_SAT_EN
      s1_en_q    <= 1'b0;
`endif
    end else if (clr_mul) begin
      idx_in_q   <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        idx_in_q <= idx_in_next;
        if (idx_in_q == '0) k_hold_q <= k_mul;
      end
      if (s1_load) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_prod_q <= prod;
          s1_idx_q  <= idx_in_q;
`ifdef ONE_UNIT_SCALE_SAT_EN
          s1_en_q   <= en_mul;
`endif
        end
      end
    end
  end

  // Stage 2 reduction to DW bits
  logic signed [DW-1:0] red_data;
`ifdef ONE_UNIT_SCALE_SAT_EN
  logic red_fits, red_ovf;

  always_comb begin
    // In range iff every bit above the DW sign bit matches it.
    red_fits = (&s1_prod_q[PW-1:DW-1]) || !(|s1_prod_q[PW-1:DW-1]);
    red_data = s1_prod_q[DW-1:0];
    red_ovf  = 1'b0;
    if (s1_en_q && !red_fits) begin
      red_ovf  = 1'b1;
      red_data = s1_prod_q[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign red_data = s1_prod_q;
`endif

  // Stage 2 (output register)
  logic signed [DW-1:0] out_data_q;
  logic [IW-1:0]        out_idx_q;
  logic                 out_last_q;
`ifdef ONE_UNIT_SCALE_SAT_EN
  logic                 ovf_q;
`endif

  always_ff @(posedge clk_mul or negedge rstn_mul) begin
    if (!rstn_mul) begin
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
`ifdef ONE_UNIT_SCALE_SAT_EN
      ovf_q      <= 1'b0;
`endif
    end else if (clr_mul) begin
      s2_valid_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= red_data;
        out_idx_q  <= s1_idx_q;
        out_last_q <= (s1_idx_q == LastIdx);
`ifdef ONE_UNIT_SCALE_SAT_EN
        ovf_q      <= red_ovf;
`endif
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
`ifdef ONE_UNIT_SCALE_SAT_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_one_unit_scale.sv
// Testbench for one_unit_scale: random and directed element streams checked against a
// behavioural model (frame position by counting accepts, coefficient per frame, result by
// plain integer arithmetic) with a scoreboard queue of expected outputs.
module tb_one_unit_scale;

  localparam int unsigned DW = 26;
  localparam int unsigned N  = 4;
  localparam int unsigned KW = 4;
  localparam int unsigned IW = $clog2(N * N);
  localparam int          FrameLen = N * N;
  localparam longint      MaxV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint      MinV = -(longint'(1) <<< (DW - 1));

  logic          clk_mul;
  logic          rstn_mul;
  logic          clr_mul;
  logic          en_mul;
  logic [KW-1:0] k_mul;

  one_unit_scale_if #(.DW(DW), .IW(IW)) bus ();

  one_unit_scale #(.DW(DW), .N(N), .KW(KW)) dut (
    .clk_mul  (clk_mul),
    .rstn_mul (rstn_mul),
    .clr_mul  (clr_mul),
    .en_mul   (en_mul),
    .k_mul    (k_mul),
    .bus      (bus)
  );

  initial begin
    clk_mul = 1'b0;
    forever #5 clk_mul = ~clk_mul;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  longint q_data[$];
  int     q_idx[$];
  bit     q_ovf[$];
  int     q_cyc[$];
  int     m_pos;      // position within the current frame
  int     m_k;        // coefficient of the current frame
  int     n_acc;      // total accepted elements
  int     cyc;
  bit     lat_chk;
  bit     stall_prev;
  longint h_data;
  int     h_idx;
  bit     h_last, h_ovf;

  function automatic longint ref_val(input longint d, input int k, input bit en,
                                     output bit o);
    longint p;
    longint m;
    o = 1'b0;
    if (!en) return d;
    p = d * k;
`ifdef ONE_UNIT_SCALE_SAT_EN
    m = 0;
    if (p > MaxV) begin o = 1'b1; return MaxV + m; end
    if (p < MinV) begin o = 1'b1; return MinV; end
    return p;
`else
    m = longint'(1) <<< DW;
    p = p % m;
    if (p < 0) p += m;
    if (p > MaxV) p -= m;
    return p;
`endif
  endfunction

  task automatic flush_model();
    q_data.delete();
    q_idx.delete();
    q_ovf.delete();
    q_cyc.delete();
    m_pos = 0;
    stall_prev = 1'b0;
  endtask

  function automatic longint rnd_data();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return longint'(r);
  endfunction

  // Compare DUT outputs with the model for the current cycle, then advance the model.
  task automatic observe();
    bit     exp_rdy;
    bit     o;
    longint v;
    exp_rdy = rstn_mul && !clr_mul && !(q_data.size() >= 2 && !bus.out_ready);
    check("in_ready", bus.in_ready, exp_rdy);
    if (q_data.size() == 0) check("idle_out_valid", bus.out_valid, 0);
    if (stall_prev) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, h_data);
      check("hold_idx", bus.out_idx, h_idx);
      check("hold_last", bus.out_last, h_last);
      check("hold_ovf", bus.ovf, h_ovf);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q_data.size() == 0) begin
        check("spurious_out_valid", bus.out_valid, 0);
      end else begin
        check("out_data", bus.out_data, q_data[0]);
        check("out_idx", bus.out_idx, q_idx[0]);
        check("out_last", bus.out_last, q_idx[0] == FrameLen - 1);
        check("ovf", bus.ovf, q_ovf[0]);
        if (lat_chk) check("latency", cyc - q_cyc[0], 2);
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
        void'(q_ovf.pop_front());
        void'(q_cyc.pop_front());
      end
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    h_data = bus.out_data;
    h_idx  = bus.out_idx;
    h_last = bus.out_last;
    h_ovf  = bus.ovf;
    if (bus.in_valid && bus.in_ready) begin
      if (m_pos == 0) m_k = k_mul;
      v = ref_val(longint'(bus.in_data), m_k, en_mul, o);
      q_data.push_back(v);
      q_idx.push_back(m_pos);
      q_ovf.push_back(o);
      q_cyc.push_back(cyc);
      m_pos = (m_pos + 1) % FrameLen;
      n_acc++;
    end
    if (clr_mul) flush_model();
    cyc++;
  endtask

  task automatic step(input bit vld, input longint d, input bit en, input int k,
                      input bit ordy, input bit clr);
    @(negedge clk_mul);
    bus.in_valid  = vld;
    bus.in_data   = DW'(d);
    en_mul        = en;
    k_mul         = KW'(k);
    bus.out_ready = ordy;
    clr_mul       = clr;
    #1;
    observe();
  endtask

  task automatic rst_pulse(input int ncyc, input bit vld);
    @(negedge clk_mul);
    rstn_mul     = 1'b0;
    bus.in_valid = vld;
    bus.in_data  = DW'(rnd_data());
    for (int i = 0; i < ncyc; i++) begin
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_idx", bus.out_idx, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_ovf", bus.ovf, 0);
      check("rst_in_ready", bus.in_ready, 0);
      @(negedge clk_mul);
    end
    flush_model();
    rstn_mul     = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q_data.size() > 0 && budget < 20) begin
      step(0, 0, 1, 0, 1, 0);
      budget++;
    end
    if (q_data.size() > 0) check("drain_timeout_pending", q_data.size(), 0);
  endtask

  initial begin
    int guard;
    int k_rnd;
    rstn_mul      = 1'b1;
    clr_mul       = 1'b0;
    en_mul        = 1'b0;
    k_mul         = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    m_pos = 0; m_k = 0; n_acc = 0; cyc = 0; lat_chk = 0; stall_prev = 0;
    #2 rstn_mul = 1'b0;

    // Reset and idle
    rst_pulse(3, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Legacy x3 with two-cycle latency
    lat_chk = 1'b1;
    for (int i = 0; i < FrameLen; i++) step(1, i + 1, 1, 3, 1, 0);
    drain();
    lat_chk = 1'b0;

    // Bypass on odd indices; coefficient change mid-frame must not take effect
    for (int i = 0; i < FrameLen; i++) step(1, rnd_data(), i % 2 == 0, (i < 3) ? 5 : 7, 1, 0);
    for (int i = 0; i < FrameLen; i++) step(1, rnd_data(), 1, 7, 1, 0);
    drain();

    // Backpressure: random valid/ready over three frames, coefficient jittering
    guard = 0;
    k_rnd = n_acc + 3 * FrameLen;
    while (n_acc < k_rnd && guard < 2000) begin
      step($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 1) != 0,
           $urandom_range(0, 15), $urandom_range(0, 1) != 0, 0);
      guard++;
    end
    if (n_acc < k_rnd) check("backpressure_timeout_accepts", n_acc, k_rnd);
    drain();

    // Overflow at k = 15, including both extremes and a bypassed extreme
    for (int i = 0; i < FrameLen; i++) begin
      case (i)
        0:       step(1, MaxV, 1, 15, 1, 0);
        1:       step(1, MinV, 1, 15, 1, 0);
        2:       step(1, MaxV, 0, 15, 1, 0);
        3:       step(1, MinV, 0, 15, 1, 0);
        default: step(1, rnd_data(), 1, 15, $urandom_range(0, 1) != 0, 0);
      endcase
    end
    drain();

    // Clear mid-frame with a simultaneous valid element
    for (int i = 0; i < 7; i++) step(1, rnd_data(), 1, 9, 1, 0);
    step(1, rnd_data(), 1, 11, 1, 1);
    step(0, 0, 1, 2, 1, 0);
    for (int i = 0; i < FrameLen; i++) step(1, rnd_data(), 1, 2, 1, 0);
    drain();

    // Same with a reset pulse instead of clear
    for (int i = 0; i < 7; i++) step(1, rnd_data(), 1, 9, 0, 0);
    rst_pulse(1, 1);
    for (int i = 0; i < FrameLen; i++) step(1, rnd_data(), 1, 6, 1, 0);
    drain();

    // Back-to-back frames with random coefficients, full throughput
    for (int f = 0; f < 2; f++) begin
      k_rnd = $urandom_range(0, 15);
      for (int i = 0; i < FrameLen; i++) step(1, rnd_data(), 1, (i == 0) ? k_rnd : 1, 1, 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
